// File: rtl/mult_pkg.sv
// Shared constants for the shift-and-add multiplier: state codes, default width, count sizing.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mult_pkg;

    localparam int MULT_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Smallest r such that 2**r >= n; used to size the step counter.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell.
// Latency: combinational.
// Backpressure: none.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/rca_nbit.sv
// WIDTH-bit ripple-carry adder chained from full_adder cells.
// Latency: combinational.
// Backpressure: none.
module rca_nbit #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] carry;

    assign carry[0] = cin;
    assign cout     = carry[WIDTH];

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (carry[i]),
            .sum  (sum[i]),
            .cout (carry[i+1])
        );
    end

endmodule

// File: rtl/shift_add_mult_ctrl.sv
// Unsigned WIDTHxWIDTH shift-and-add multiplier sharing one ripple-carry adder (optional ZERO_BYPASS_EN).
// Latency: done pulses WIDTH+1 cycles after start is sampled (1 cycle for zero operands with ZERO_BYPASS_EN).
// Backpressure: start is only accepted in IDLE or DONE; start during RUN is ignored.
module shift_add_mult_ctrl
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = clog2(WIDTH + 1);

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   m, q, acc;
    logic               carry;
    logic [CW-1:0]      count;
    logic               load, step, bypass;

    logic [WIDTH-1:0]   add_b, add_sum;
    logic               add_cout;
    logic [2*WIDTH:0]   shifted;

`ifdef ZERO_BYPASS_EN
    assign bypass = (multiplicand == '0) || (multiplier == '0);
`else
    assign bypass = 1'b0;
`endif

    // C always shifts out as 0, so feeding it back is the same as a zero carry-in.
    assign add_b = q[0] ? m : '0;

    rca_nbit #(.WIDTH(WIDTH)) u_rca (
        .a    (acc),
        .b    (add_b),
        .cin  (carry),
        .sum  (add_sum),
        .cout (add_cout)
    );

    assign shifted = {add_cout, add_sum, q} >> 1;

    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);

    // Next-state decode: accept start in IDLE/DONE, step WIDTH times in RUN.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                state_nxt = ST_IDLE;
                if (start) begin
                    load      = 1'b1;
                    state_nxt = bypass ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                step = 1'b1;
                if (count == CW'(WIDTH - 1)) state_nxt = ST_DONE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State, operand/accumulator registers and the registered product.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            m       <= '0;
            q       <= '0;
            acc     <= '0;
            carry   <= 1'b0;
            count   <= '0;
            product <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                m     <= multiplicand;
                q     <= multiplier;
                acc   <= '0;
                carry <= 1'b0;
                count <= '0;
                if (bypass) product <= '0;
            end else if (step) begin
                {carry, acc, q} <= shifted;
                count           <= count + CW'(1);
                if (state_nxt == ST_DONE) product <= shifted[2*WIDTH-1:0];
            end
        end
    end

endmodule

// File: doc/shift_add_mult_ctrl.md
Name: shift_add_mult_ctrl

Overview:
- Sequential unsigned WIDTH x WIDTH multiplier controller that time-shares one WIDTH-bit ripple-carry adder using the shift-and-add method.
- Accepts operands on a start pulse and steps the adder once per cycle for WIDTH cycles.
- Presents a 2*WIDTH-bit product with a one-cycle done pulse.
- Sits between a requesting datapath/testbench and the adder resource; first clocked block in the arithmetic library.

Parameters:
WIDTH, 4, operand width in bits; product is 2*WIDTH bits; legal range 2..16

Ports:
clk           input   1          system clock, rising-edge
rst           input   1          synchronous active-high reset
start         input   1          request; sampled only in IDLE or DONE
multiplicand  input   WIDTH      operand M, captured when start accepted
multiplier    input   WIDTH      operand Q, captured when start accepted
busy          output  1          high while in RUN
done          output  1          one-cycle pulse, product valid
product       output  2*WIDTH    result; holds until next accepted start or reset

Behaviour:
- Interface (already decided): one clock; reset is synchronous and active-high, on clk and rst.
- Reset: state=IDLE; busy=0, done=0, product=0; all internal registers (ACC, C, Q, M, count) = 0. Reset wins over start in the same cycle.
- States: IDLE, RUN, DONE. Encoding 2-bit: IDLE=0, RUN=1, DONE=2; code 3 is illegal and goes to IDLE.
- IDLE:
  - start=1 -> capture M<=multiplicand, Q<=multiplier, ACC<=0, C<=0, count<=0; go to RUN.
  - start=0 -> stay.
- RUN, each cycle:
  - Adder input a=ACC; b=(Q[0] ? M : 0); cin=0.
  - {C,ACC,Q} <= {cout,sum,Q} >> 1, a logical shift right of the concatenation by 1.
  - count <= count+1.
  - When count==WIDTH-1 after this step, go to DONE.
- DONE:
  - product <= {ACC,Q} on RUN->DONE transition; done=1 for exactly this one cycle.
  - If start=1 here, capture new operands and go directly to RUN (back-to-back). Otherwise go to IDLE.
- Latency: start accepted at edge N -> busy high from N+1 through N+WIDTH. done high in the cycle after edge N+WIDTH, i.e. done visible WIDTH+1 cycles after start sampled.
- start while busy (RUN) is ignored; operands are not re-sampled.
- Operand inputs may change freely after acceptance.
- product is registered and never shows intermediate values.
- Arithmetic: unsigned. Adder carry-out is kept in C, so no overflow is possible; max result (2^WIDTH-1)^2 fits in 2*WIDTH bits.
- count is ceil(log2(WIDTH+1)) bits; no wrap-around inside RUN.
- Reset mid-RUN: abort immediately to IDLE; product clears to 0; no done pulse.

Optional Feature:
- Macro: ZERO_BYPASS_EN.
- Defined: if multiplicand==0 or multiplier==0 when start is accepted, go straight to DONE instead of RUN. done is asserted the cycle after acceptance with product=0, and busy never rises.
- Undefined: zero operands take the full WIDTH-cycle RUN sequence (result still 0).

Decomposition:
- Shared package/include mult_pkg:
  - State encodings ST_IDLE, ST_RUN, ST_DONE.
  - Default width constant MULT_WIDTH=4.
  - Count-width function clog2.
- One sub-module: rca_nbit, a parameterised WIDTH-bit ripple-carry adder built from the existing full-adder cell.
  - Ports a, b, cin, sum, cout.
  - Instantiated once and combinationally driven by the controller.

Test Plan:
- Reset then start with 15,15 (WIDTH=4) -> busy high 4 cycles; done pulse on 5th cycle after start; product=225; busy=0.
- Start 13,11 followed immediately by start 6,7 in the DONE cycle -> product=143 with done, then next done with product=42. No IDLE cycle between runs.
- Start 9,5; assert start with 2,2 during RUN cycles 1-3 -> ignored; product=45; only one done pulse.
- Start 12,10; assert rst in RUN cycle 2 -> next cycle busy=0, done=0, product=0. No done pulse follows; a fresh start 3,3 then yields 9.
- Start 0,9:
  - Without ZERO_BYPASS_EN -> done after 5 cycles, product=0.
  - With it -> done on the next cycle, busy never 1, product=0.
- Exhaustive sweep of all 256 operand pairs, WIDTH=4 -> every product equals A*B; done count equals 256.
